// File: rtl/regbank_alu_datapath_pkg.sv
// Shared constants for the register-bank / ALU datapath.
//   - ALU opcode encodings (3-bit)
//   - NO_WRITE write-back address (all-ones register address)
//   - bit positions inside the 5-bit flag vector
package regbank_alu_datapath_pkg;

  localparam int ALU_W  = 3;
  localparam int DECO_W = 3;
  localparam int FLG_W  = 5;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SHL  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SHR  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b110;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'b111;

  localparam logic [DECO_W-1:0] NO_WRITE = '1;

  // flag vector layout: {V, C, N, Z, P}
  localparam int FLG_P = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_C = 3;
  localparam int FLG_V = 4;

endpackage

// File: rtl/regbank_alu_datapath_alu_core.sv
// Purely combinational ALU.
//   i_a, i_b : operands (WIDTH)
//   i_op     : opcode (ALU_W)
//   o_res    : result (WIDTH)
//   o_flags  : {V, C, N, Z, P} for the result
module alu_core
  import regbank_alu_datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [ALU_W-1:0] i_op,
  output logic [WIDTH-1:0] o_res,
  output logic [FLG_W-1:0] o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // extra top bit gives carry-out for add and borrow for sub
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_res = i_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      ALU_PASS: w_res = i_a;
      ALU_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_SHL: begin
        w_res = {i_a[WIDTH-2:0], 1'b0};
        w_c   = i_a[WIDTH-1];
        w_v   = i_a[WIDTH-1] ^ i_a[WIDTH-2];
      end
      ALU_SHR: begin
        w_res = {1'b0, i_a[WIDTH-1:1]};
        w_c   = i_a[0];
      end
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      default: w_res = i_a;
    endcase
  end

  assign o_res          = w_res;
  assign o_flags[FLG_V] = w_v;
  assign o_flags[FLG_C] = w_c;
  assign o_flags[FLG_N] = w_res[WIDTH-1];
  assign o_flags[FLG_Z] = (w_res == '0);
  assign o_flags[FLG_P] = ^w_res;

endmodule

// File: rtl/regbank_alu_datapath.sv
// Register bank + ALU + flag register for the x2-multiplier datapath.
//   clk, lowRst          : clock (rising), async active-low reset
//   sSelDecoA/B          : combinational read addresses for ALU operands
//   sSelDecoC            : write-back address, all-ones = no write, flags hold
//   sSelAlu              : ALU opcode
//   iLoadEn/Addr/Data    : external preload port, wins over write-back on
//                          the same address, never touches flags
//   sOverflow..sPar      : registered flags of the last committed write-back
//   oResult              : copy of R0
//   oAluOut              : combinational ALU result
module regbank_alu_datapath
  import regbank_alu_datapath_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SELECTIONALU  = ALU_W,
  parameter int SELECTIONDECO = DECO_W
) (
  input  logic                     clk,
  input  logic                     lowRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic                     iLoadEn,
  input  logic [SELECTIONDECO-1:0] iLoadAddr,
  input  logic [WIDTH-1:0]         iLoadData,
  output logic                     sOverflow,
  output logic                     sCarry,
  output logic                     sNegative,
  output logic                     sZero,
  output logic                     sPar,
  output logic [WIDTH-1:0]         oResult,
  output logic [WIDTH-1:0]         oAluOut
);

  localparam int NREG = 2 ** SELECTIONDECO;

  logic [NREG-1:0][WIDTH-1:0] r_regs;
  logic [FLG_W-1:0]           r_flags;
  logic [WIDTH-1:0]           w_a;
  logic [WIDTH-1:0]           w_b;
  logic [WIDTH-1:0]           w_res;
  logic [FLG_W-1:0]           w_flags;
  logic                       w_wb;

  // no bypass: operands always see the pre-edge register contents
  assign w_a  = r_regs[sSelDecoA];
  assign w_b  = r_regs[sSelDecoB];
  assign w_wb = (sSelDecoC != NO_WRITE);

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_op    (sSelAlu),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // load is checked first so it wins an address collision
        if (iLoadEn && (iLoadAddr == SELECTIONDECO'(i)))
          r_regs[i] <= iLoadData;
        else if (w_wb && (sSelDecoC == SELECTIONDECO'(i)))
          r_regs[i] <= w_res;
      end
    end
  end

  // flags follow the ALU on every write-back, even when a load took the register
  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst)   r_flags <= '0;
    else if (w_wb) r_flags <= w_flags;
  end

  assign sOverflow = r_flags[FLG_V];
  assign sCarry    = r_flags[FLG_C];
  assign sNegative = r_flags[FLG_N];
  assign sZero     = r_flags[FLG_Z];
  assign sPar      = r_flags[FLG_P];
  assign oResult   = r_regs[0];
  assign oAluOut   = w_res;

endmodule

// File: tb/tb_regbank_alu_datapath.sv
module tb_regbank_alu_datapath;

  logic       clk = 1'b0;
  logic       lowRst;
  logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, iLoadAddr;
  logic       iLoadEn;
  logic [7:0] iLoadData;
  logic       sOverflow, sCarry, sNegative, sZero, sPar;
  logic [7:0] oResult, oAluOut;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  regbank_alu_datapath #(.WIDTH(8), .SELECTIONALU(3), .SELECTIONDECO(3)) dut (
    .clk       (clk),
    .lowRst    (lowRst),
    .sSelDecoA (sSelDecoA),
    .sSelDecoB (sSelDecoB),
    .sSelDecoC (sSelDecoC),
    .sSelAlu   (sSelAlu),
    .iLoadEn   (iLoadEn),
    .iLoadAddr (iLoadAddr),
    .iLoadData (iLoadData),
    .sOverflow (sOverflow),
    .sCarry    (sCarry),
    .sNegative (sNegative),
    .sZero     (sZero),
    .sPar      (sPar),
    .oResult   (oResult),
    .oAluOut   (oAluOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // flag vector {V,C,N,Z,P}
  task automatic chk_flg(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, sOverflow, sCarry, sNegative, sZero, sPar}, {27'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // peek a register through the pass opcode; write-back must be idle
  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    logic [2:0] sa, so;
    sa = sSelDecoA; so = sSelAlu;
    sSelDecoA = addr; sSelAlu = 3'b000;
    #1;
    chk(tag, {24'd0, oAluOut}, {24'd0, exp});
    sSelDecoA = sa; sSelAlu = so;
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    sSelDecoC = 3'd7;
    iLoadEn = 1'b1; iLoadAddr = addr; iLoadData = data;
    tick;
    iLoadEn = 1'b0;
  endtask

  task automatic op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] o);
    sSelDecoA = a; sSelDecoB = b; sSelDecoC = c; sSelAlu = o;
    tick;
    sSelDecoC = 3'd7;
  endtask

  initial begin
    lowRst = 1'b0; iLoadEn = 1'b0; iLoadAddr = '0; iLoadData = '0;
    sSelDecoA = '0; sSelDecoB = '0; sSelDecoC = 3'd7; sSelAlu = '0;
    #3;
    chk("rst_result", {24'd0, oResult}, 32'h0);
    chk_flg("rst_flags", 5'b00000);
    #9 lowRst = 1'b1;
    tick;

    // async reset mid-cycle after state has been built up
    load(3'd0, 8'h55);
    load(3'd6, 8'h80);
    op(3'd6, 3'd0, 3'd5, 3'b100);
    chk("pre_rst_r0", {24'd0, oResult}, 32'h55);
    chk_flg("pre_rst_flags", 5'b11010);
    #2 lowRst = 1'b0;
    #1;
    chk("async_rst_r0", {24'd0, oResult}, 32'h0);
    chk_flg("async_rst_flags", 5'b00000);
    for (int i = 0; i < 8; i++) chk_reg($sformatf("async_rst_r%0d", i), 3'(i), 8'h00);
    lowRst = 1'b1;
    tick;

    // shift left with carry / overflow
    load(3'd6, 8'hC1);
    op(3'd6, 3'd0, 3'd0, 3'b100);
    chk("shl_c1", {24'd0, oResult}, 32'h82);
    chk_flg("shl_c1_flags", 5'b01100);
    load(3'd6, 8'h40);
    op(3'd6, 3'd0, 3'd0, 3'b100);
    chk("shl_40", {24'd0, oResult}, 32'h80);
    chk_flg("shl_40_flags", 5'b10101);
    load(3'd6, 8'h80);
    op(3'd6, 3'd0, 3'd0, 3'b100);
    chk("shl_80", {24'd0, oResult}, 32'h00);
    chk_flg("shl_80_flags", 5'b11010);

    // x2 sequence: two C=7 cycles must leave R0 and flags alone
    load(3'd6, 8'h35);
    chk_flg("load_keeps_flags", 5'b11010);
    op(3'd6, 3'd0, 3'd7, 3'b000);
    chk("x2_c1_r0", {24'd0, oResult}, 32'h00);
    chk_flg("x2_c1_flags", 5'b11010);
    op(3'd6, 3'd0, 3'd7, 3'b100);
    chk("x2_c2_r0", {24'd0, oResult}, 32'h00);
    chk_flg("x2_c2_flags", 5'b11010);
    op(3'd6, 3'd0, 3'd0, 3'b100);
    chk("x2_r0", {24'd0, oResult}, 32'h6A);
    chk_flg("x2_flags", 5'b00000);

    // arithmetic
    load(3'd1, 8'h7F);
    load(3'd2, 8'h01);
    op(3'd1, 3'd2, 3'd3, 3'b001);
    chk_reg("add_r3", 3'd3, 8'h80);
    chk_flg("add_flags", 5'b10101);
    op(3'd2, 3'd1, 3'd4, 3'b010);
    chk_reg("sub_r4", 3'd4, 8'h82);
    chk_flg("sub_flags", 5'b01100);

    // no-write address
    sSelDecoA = 3'd1; sSelDecoB = 3'd2; sSelAlu = 3'b001; #1;
    chk("nowr_aluout", {24'd0, oAluOut}, 32'h80);
    op(3'd1, 3'd2, 3'd7, 3'b001);
    chk_flg("nowr_flags", 5'b01100);
    chk_reg("nowr_r3", 3'd3, 8'h80);
    chk_reg("nowr_r4", 3'd4, 8'h82);
    chk_reg("nowr_r7", 3'd7, 8'h00);

    // same-address collision: load wins, flags from ALU
    iLoadEn = 1'b1; iLoadAddr = 3'd0; iLoadData = 8'hAA;
    op(3'd6, 3'd0, 3'd0, 3'b100);
    iLoadEn = 1'b0;
    chk("coll_r0", {24'd0, oResult}, 32'hAA);
    chk_flg("coll_flags", 5'b00000);
    // different-address collision: both land
    iLoadEn = 1'b1; iLoadAddr = 3'd1; iLoadData = 8'h11;
    op(3'd6, 3'd0, 3'd5, 3'b100);
    iLoadEn = 1'b0;
    chk_reg("coll2_r5", 3'd5, 8'h6A);
    chk_reg("coll2_r1", 3'd1, 8'h11);

    // shr / logic ops on R6=0x35, R2=0x01
    op(3'd6, 3'd0, 3'd3, 3'b101);
    chk_reg("shr_r3", 3'd3, 8'h1A);
    chk_flg("shr_flags", 5'b01001);
    op(3'd6, 3'd2, 3'd3, 3'b111);
    chk_reg("xor_r3", 3'd3, 8'h34);
    chk_flg("xor_flags", 5'b00001);

    // read-before-write on R0
    load(3'd0, 8'h03);
    op(3'd0, 3'd0, 3'd0, 3'b100);
    chk("rbw_1", {24'd0, oResult}, 32'h06);
    op(3'd0, 3'd0, 3'd0, 3'b100);
    chk("rbw_2", {24'd0, oResult}, 32'h0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_alu_datapath.md
Name: regbank_alu_datapath

Overview:
Datapath stage directly downstream of the x2-multiplier control FSM. It consumes that FSM's sSelDecoA/B/C and sSelAlu and feeds sOverflow/sCarry/sNegative/sZero/sPar back to it.
- Contains an 8-entry register bank with two combinational read ports (A, B) and one write-back port (C).
- Contains a 3-bit-opcode ALU and a registered flag bank.
- An external load port preloads operands (e.g. R6) before sStart; R0 is exported as the result.

Parameters:
WIDTH, 8, data width of registers and ALU
SELECTIONALU, 3, ALU opcode width
SELECTIONDECO, 3, register address width (2**SELECTIONDECO registers)

Ports:
clk  in  1  clock, rising edge
lowRst  in  1  asynchronous, active-low reset
sSelDecoA  in  SELECTIONDECO  read address, ALU operand A
sSelDecoB  in  SELECTIONDECO  read address, ALU operand B
sSelDecoC  in  SELECTIONDECO  write-back address; all-ones = no write
sSelAlu  in  SELECTIONALU  ALU opcode
iLoadEn  in  1  external load strobe
iLoadAddr  in  SELECTIONDECO  external load address (any register, including 7)
iLoadData  in  WIDTH  external load data
sOverflow, sCarry, sNegative, sZero, sPar  out  1 each  registered flags
oResult  out  WIDTH  current contents of R0
oAluOut  out  WIDTH  combinational ALU result (debug/observe)

Behaviour:
- Reset (lowRst=0, async): all registers R0..R7 = 0, all flags = 0, oResult = 0. Reset mid-operation discards everything, with no partial write.
- Read ports: A = R[sSelDecoA], B = R[sSelDecoB], both combinational. Reads return the pre-edge value; there is no write-through bypass.
- ALU (combinational, result WIDTH bits):
  - 000 pass A
  - 001 A+B
  - 010 A-B
  - 011 A&B
  - 100 shift left A by 1, LSB filled with 0
  - 101 logical shift right A by 1
  - 110 A|B
  - 111 A^B
- Carry:
  - add: carry-out.
  - sub: borrow (1 when A<B unsigned).
  - shl: the old A[WIDTH-1].
  - shr: the old A[0].
  - logic ops and pass: 0.
- Overflow (signed):
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from A.
  - shl: A[WIDTH-1] != A[WIDTH-2].
  - all other ops: 0.
- Negative = result MSB. Zero = (result==0). Par = XOR-reduction of the result (1 = odd number of ones).
- Write-back: on the clk rising edge, if sSelDecoC != all-ones, then R[sSelDecoC] <= ALU result and all five flags <= ALU flags, in the same edge. Latency from operand select to visible R/flags is 1 edge.
- sSelDecoC == all-ones: no register write and the flags hold. R7 is therefore writable only through the load port.
- Load port: if iLoadEn=1 then R[iLoadAddr] <= iLoadData on the edge. Loads never change flags.
- Simultaneous load and write-back:
  - Different addresses: both occur.
  - Same address: the load wins and the flags still update from the ALU.
- oResult is a continuous copy of R0, so it updates 1 edge after the write.
- Flags are registered, so the FSM's next-state logic sees flags of the last committed write-back.

Decomposition:
- Shared package: ALU opcode constants (ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_SHL, ALU_SHR, ALU_OR, ALU_XOR), the NO_WRITE address constant (all-ones), and flag-vector bit indices.
- One natural sub-module, alu_core: purely combinational. Inputs are A, B and the opcode; outputs are the result and the 5 flags.
- The register bank and flag register stay in the top.

Test Plan:
- Reset check: assert lowRst=0 mid-cycle after a prior write of R0=0x55 -> R0..R7=0, all flags 0 immediately (asynchronous, no clk edge needed).
- x2 sequence, WIDTH=8:
  - Stimulus: load R6=0x35, then drive A=6 B=0 C=7 op=000 (1 cycle), op=100 C=7 (1 cycle), op=100 C=0 (1 cycle).
  - Response: R0=0x6A and flags C=0 V=0 N=0 Z=0 P=0, only after the third edge. No flag change during the C=7 cycles.
- Shift with carry and overflow:
  - R6=0xC1 shl into R0 -> 0x82, C=1 V=0 N=1 Z=0 P=0.
  - R6=0x40 -> 0x80, C=0 V=1 N=1 P=1.
  - R6=0x80 -> 0x00, C=1 V=1 Z=1 N=0 P=0.
- Arithmetic:
  - R1=0x7F, R2=0x01, add into R3 -> 0x80, V=1 N=1 C=0.
  - sub R2-R1 into R4 -> 0x82, C=1 (borrow) V=0 N=1.
- No-write and collision:
  - C=111 with op=001 -> no register changes and flags hold the previous values.
  - iLoadEn with iLoadAddr=0, iLoadData=0xAA, in the same cycle as write-back C=0 of 0x6A -> R0=0xAA, flags from 0x6A.
- Read-before-write: A=0, C=0, op=100 for two consecutive cycles with R0=0x03 -> R0=0x06, then 0x0C. Each edge uses the pre-edge value.
